bus_initiator_68k: RTL

- 68000-style asynchronous bus master, the initiator end of the AS/UDS/LDS/DTACK handshake our bus control logic answers.
- FPGA-side logic (loader, memory tester, single-step monitor) issues word or byte read/write requests.
- The block sequences address, strobes and R/W, waits for DTACK or bus error, and times out.
- Used to exercise target memory/peripherals through the same bus protocol the CPU uses.

---
 rtl/bus68k_pkg.sv | 63 ++++++
 rtl/bus_sync.sv | 21 ++
 rtl/bus_initiator_68k.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bus68k_pkg.sv
// Shared types and constants for the 68000-style bus initiator: state encoding,
// strobe levels, bus widths and the per-state bus control decode.
package bus68k_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic STRB_ON  = 1'b0;
  localparam logic STRB_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_WAIT,
    ST_LATCH,
    ST_END
  } bus_state_e;

  typedef struct packed {
    logic as_n;
    logic uds_n;
    logic lds_n;
    logic rw;
    logic data_oe;
  } bus_ctl_t;

  localparam bus_ctl_t CTL_IDLE = '{as_n: STRB_OFF, uds_n: STRB_OFF, lds_n: STRB_OFF,
                                    rw: 1'b1, data_oe: 1'b0};

  // Bus pin levels for a given state. Write data strobes trail AS by one cycle
  // so the data bus has settled before the target sees UDS/LDS.
  function automatic bus_ctl_t decode_ctl(bus_state_e st, logic rw, logic [1:0] be);
    bus_ctl_t c;
    c = CTL_IDLE;
    case (st)
      ST_ADDR: c.rw = rw;
      ST_STRB: begin
        c.rw      = rw;
        c.as_n    = STRB_ON;
        c.data_oe = ~rw;
        if (rw) begin
          c.uds_n = ~be[1];
          c.lds_n = ~be[0];
        end
      end
      ST_WAIT, ST_LATCH: begin
        c.rw      = rw;
        c.as_n    = STRB_ON;
        c.uds_n   = ~be[1];
        c.lds_n   = ~be[0];
        c.data_oe = ~rw;
      end
      ST_END: begin
        c.rw      = rw;
        c.data_oe = ~rw;
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// N-stage synchronizer for an asynchronous active-low bus input; resets to the
// negated (high) level so a reset never looks like an acknowledge.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic CPUCLK_IN,
  input  logic RESETN_IN,
  input  logic async_d,
  output logic sync_q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge CPUCLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) ff <= '1;
    else            ff <= {ff[STAGES-2:0], async_d};
  end

  assign sync_q = ff[STAGES-1];

endmodule

// File: rtl/bus_initiator_68k.sv
// 68000-style asynchronous bus master: sequences ADDR/AS/UDS/LDS/RW for a single
// word or byte transfer, waits for DTACK or BERR, and terminates on timeout.
module bus_initiator_68k
  import bus68k_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              CPUCLK_IN,
  input  logic              RESETN_IN,
  input  logic              REQ_IN,
  input  logic              RW_IN,
  input  logic [1:0]        BE_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] WDATA_IN,
  output logic              BUSY_OUT,
  output logic              ACK_OUT,
  output logic              ERR_OUT,
  output logic [DATA_W-1:0] RDATA_OUT,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic              RW_OUT,
  output logic              AS_N_OUT,
  output logic              UDS_N_OUT,
  output logic              LDS_N_OUT,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE_OUT,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              DTACK_N_IN,
  input  logic              BERR_N_IN
);

  bus_state_e        state_q, state_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        be_q, be_d;
  logic              accept;
  logic              ack_d, err_d;
  logic              ack_q, err_q;
  bus_ctl_t          ctl_q;
  logic              dtack_n_s, berr_n_s;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
    .CPUCLK_IN (CPUCLK_IN),
    .RESETN_IN (RESETN_IN),
    .async_d   (DTACK_N_IN),
    .sync_q    (dtack_n_s)
  );

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync_berr (
    .CPUCLK_IN (CPUCLK_IN),
    .RESETN_IN (RESETN_IN),
    .async_d   (BERR_N_IN),
    .sync_q    (berr_n_s)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    accept     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ_IN) begin
          if (BE_IN != 2'b00) begin
            state_d = ST_ADDR;
            accept  = 1'b1;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR:  state_d = ST_STRB;
      ST_STRB:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (!dtack_n_s) begin
          state_d = ST_LATCH;
        end else if (!berr_n_s) begin
          state_d = ST_END;
          err_d   = 1'b1;
        end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_END;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_LATCH: state_d = ST_END;
      ST_END:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_d == ST_END) ack_d = 1'b1;
  end

  // The request fields are only latched at the accepting edge, so the pin
  // decode for the ADDR state has to look at the live inputs.
  assign rw_d = accept ? RW_IN : rw_q;
  assign be_d = accept ? BE_IN : be_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CPUCLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ctl_q      <= CTL_IDLE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ctl_q      <= decode_ctl(state_d, rw_d, be_d);
    end
  end

  always_ff @(posedge CPUCLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) begin
      addr_q  <= '0;
      rw_q    <= 1'b1;
      be_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= ADDR_IN;
        rw_q   <= RW_IN;
        be_q   <= BE_IN;
        if (!RW_IN) wdata_q <= WDATA_IN;
      end
      if (state_q == ST_LATCH && rw_q) rdata_q <= DATA_IN;
    end
  end

  assign BUSY_OUT    = (state_q != ST_IDLE);
  assign ACK_OUT     = ack_q;
  assign ERR_OUT     = err_q;
  assign RDATA_OUT   = rdata_q;
  assign ADDR_OUT    = addr_q;
  assign DATA_OUT    = wdata_q;
  assign RW_OUT      = ctl_q.rw;
  assign AS_N_OUT    = ctl_q.as_n;
  assign UDS_N_OUT   = ctl_q.uds_n;
  assign LDS_N_OUT   = ctl_q.lds_n;
  assign DATA_OE_OUT = ctl_q.data_oe;

endmodule
